// File: rtl/mem_seq_ctrl_if.sv
// Command, write-data, read-data and memory-pin bundle between a requester and mem_seq_ctrl.
interface mem_seq_ctrl_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wd_valid;
  logic          wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;
  logic          busy;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, mem_dout,
    input  cmd_ready, wd_ready, rd_valid, rd_data, done, err, busy,
           mem_cs, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, mem_dout,
    output cmd_ready, wd_ready, rd_valid, rd_data, done, err, busy,
           mem_cs, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Burst read/write sequencer for the 5x16 register-file memory; memory strobes launch on the
// falling edge so addr/din are settled before the rising edge that clocks the row.
module mem_seq_ctrl #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 16
) (
  input  logic               clkp,
  input  logic               rstp,
  mem_seq_ctrl_if.slave      bus
);

  localparam int unsigned SW = AW + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_WAIT  = 3'd1,
    WR_STRB  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_HOLD  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          wd_ready_q, wd_ready_d;

  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;

  logic [SW-1:0] end_sum_c;
  logic          reject_c;

  // Range check on the unwrapped end address
  assign end_sum_c = SW'(bus.cmd_addr) + SW'(bus.cmd_len);
  assign reject_c  = (bus.cmd_len == '0) || (end_sum_c > SW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          if (reject_c) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.cmd_addr;
            cnt_d   = bus.cmd_len;
            state_d = bus.cmd_wr ? WR_WAIT : RD_ISSUE;
          end
        end
      end
      WR_WAIT: begin
        if (bus.wd_valid) begin
          data_d  = bus.wd_data;
          state_d = WR_STRB;
        end
      end
      WR_STRB: begin
        cnt_d  = cnt_q - AW'(1);
        addr_d = addr_q + AW'(1);
        if (cnt_q == AW'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WR_WAIT;
        end
      end
      RD_ISSUE: begin
        rd_data_d  = bus.mem_dout;
        rd_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          cnt_d      = cnt_q - AW'(1);
          addr_d     = addr_q + AW'(1);
          if (cnt_q == AW'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    wd_ready_d  = (state_d == WR_WAIT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wd_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      wd_ready_q  <= wd_ready_d;
    end
  end

  // Memory pins follow the posedge state half a cycle later; addr/din hold while idle
  always_comb begin
    mem_cs_d   = (state_q == WR_STRB) || (state_q == RD_ISSUE);
    mem_we_d   = (state_q == WR_STRB);
    mem_addr_d = mem_cs_d ? addr_q : mem_addr_q;
    mem_din_d  = mem_we_d ? data_q : mem_din_q;
  end

  always_ff @(negedge clkp or posedge rstp) begin
    if (rstp) begin
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wd_ready  = wd_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl with a 5x16 register-file memory model behind it.
module tb_mem_seq_ctrl;

  logic clkp = 1'b0;
  logic rstp = 1'b1;

  mem_seq_ctrl_if #(.AW(3), .DW(16)) bus ();

  mem_seq_ctrl #(.DEPTH(5), .AW(3), .DW(16)) dut (
    .clkp (clkp),
    .rstp (rstp),
    .bus  (bus.slave)
  );

  always #5 clkp = ~clkp;

  // Register-file memory: row clocked by clk&we&cs, asynchronous read
  logic [15:0] mem [0:7];
  always @(posedge clkp) if (bus.mem_cs && bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
  assign bus.mem_dout = mem[bus.mem_addr];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cs_cnt = 0;
  int edge_viol = 0;
  int we_viol = 0;
  int addr_viol = 0;
  logic [3:0] alog [$];
  logic [15:0] wbuf [0:4];
  logic [15:0] ebuf [0:4];

  always @(negedge clkp) if (!rstp) begin
    if (bus.done) done_cnt++;
    if (bus.err)  err_cnt++;
  end

  always @(posedge clkp) if (!rstp && bus.mem_cs) begin
    cs_cnt++;
    alog.push_back({bus.mem_we, bus.mem_addr});
    if (bus.mem_addr > 3'd4) addr_viol++;
  end

  always @(bus.mem_cs or bus.mem_we or bus.mem_addr or bus.mem_din)
    if (!rstp && clkp !== 1'b0) edge_viol++;

  always @(negedge clkp) begin
    #2;
    if (bus.mem_we && !bus.mem_cs) we_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [2:0] a, input logic [2:0] l);
    int g = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && g < 50) begin tick(); g++; end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.busy && g < 100) begin tick(); g++; end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
    tick();
  endtask

  task automatic write_burst(input logic [2:0] a, input int n);
    send_cmd(1'b1, a, 3'(n));
    for (int i = 0; i < n; i++) begin
      int g = 0;
      bus.wd_valid = 1'b1;
      bus.wd_data  = wbuf[i];
      while (!bus.wd_ready && g < 50) begin tick(); g++; end
      chk("wd_ready_wait", 32'(bus.wd_ready), 32'd1);
      tick();
      bus.wd_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic read_burst(input logic [2:0] a, input int n, input int hold);
    int d0 = done_cnt;
    send_cmd(1'b0, a, 3'(n));
    for (int i = 0; i < n; i++) begin
      int g = 0;
      while (!bus.rd_valid && g < 50) begin tick(); g++; end
      chk("rd_valid_wait", 32'(bus.rd_valid), 32'd1);
      chk("rd_data", 32'(bus.rd_data), 32'(ebuf[i]));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_rd_data", 32'(bus.rd_data), 32'(ebuf[i]));
        chk("hold_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("hold_mem_cs", 32'(bus.mem_cs), 32'd0);
      end
      if (hold > 0 && i == n - 1) chk("no_early_done", 32'(done_cnt - d0), 32'd0);
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int d0;
    int c0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.rd_ready = 1'b0;

    // Reset state
    #13;
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    chk("rst_cs_we", {30'd0, bus.mem_cs, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    #10 rstp = 1'b0;
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 1: single write then single read at row 2
    d0 = done_cnt;
    wbuf[0] = 16'hA5C3;
    write_burst(3'd2, 1);
    chk("t1_row2", 32'(mem[2]), 32'h0000A5C3);
    chk("t1_wr_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    ebuf[0] = 16'hA5C3;
    read_burst(3'd2, 1, 0);
    chk("t1_rd_done", 32'(done_cnt - d0), 32'd1);

    // 2: full-depth burst write and read
    for (int i = 0; i < 5; i++) begin
      wbuf[i] = 16'(16'h1111 * (i + 1));
      ebuf[i] = wbuf[i];
    end
    alog.delete();
    d0 = done_cnt;
    write_burst(3'd0, 5);
    chk("t2_wr_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_wr_log_n", 32'(alog.size()), 32'd5);
    for (int i = 0; i < 5 && i < alog.size(); i++)
      chk("t2_wr_addr", 32'(alog[i]), 32'(8 + i));
    for (int i = 0; i < 5; i++) chk("t2_row", 32'(mem[i]), 32'(ebuf[i]));
    alog.delete();
    d0 = done_cnt;
    read_burst(3'd0, 5, 0);
    chk("t2_rd_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_rd_log_n", 32'(alog.size()), 32'd5);
    for (int i = 0; i < 5 && i < alog.size(); i++)
      chk("t2_rd_addr", 32'(alog[i]), 32'(i));

    // 3: out-of-range and zero-length commands
    c0 = cs_cnt;
    d0 = err_cnt;
    send_cmd(1'b1, 3'd3, 3'd3);
    chk("t3a_err", 32'(bus.err), 32'd1);
    chk("t3a_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t3a_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("t3a_err_clr", 32'(bus.err), 32'd0);
    send_cmd(1'b0, 3'd0, 3'd0);
    chk("t3b_err", 32'(bus.err), 32'd1);
    tick();
    chk("t3b_err_clr", 32'(bus.err), 32'd0);
    send_cmd(1'b0, 3'd7, 3'd7);
    chk("t3c_err", 32'(bus.err), 32'd1);
    tick();
    tick();
    chk("t3_err_pulses", 32'(err_cnt - d0), 32'd3);
    chk("t3_no_cs", 32'(cs_cnt - c0), 32'd0);

    // 4: read with backpressure
    d0 = done_cnt;
    read_burst(3'd0, 3, 4);
    chk("t4_done", 32'(done_cnt - d0), 32'd1);

    // 5: reset during a write strobe
    d0 = done_cnt;
    send_cmd(1'b1, 3'd0, 3'd4);
    bus.wd_valid = 1'b1;
    bus.wd_data  = 16'h9999;
    tick();
    bus.wd_valid = 1'b0;
    #5;
    chk("t5_strb_cs_we", {30'd0, bus.mem_cs, bus.mem_we}, 32'd3);
    rstp = 1'b1;
    #1;
    chk("t5_async_cs_we", {30'd0, bus.mem_cs, bus.mem_we}, 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    #12 rstp = 1'b0;
    tick();
    tick();
    chk("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t5_busy_after", 32'(bus.busy), 32'd0);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_row0_kept", 32'(mem[0]), 32'h00001111);

    // 6: pin-timing invariants over the whole run
    chk("t6_edge_viol", 32'(edge_viol), 32'd0);
    chk("t6_we_no_cs", 32'(we_viol), 32'd0);
    chk("t6_addr_range", 32'(addr_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
